div_result_bcd: RTL and testbench
=================================

# div_result_bcd

Sequential binary-to-BCD converter that sits directly downstream of the team's integer divider. It samples the divider's registered Quotient and Remainder on a Start pulse and converts both in parallel with shift-and-add-3 (double-dabble), one bit per clock. It presents packed BCD digits for the seven-segment display stage and signals completion with a one-cycle Done pulse.

## Interface
- WIDTH, 4, bit width of Quotient and Remainder; must match the divider's WIDTH.
- DIGITS, 2, BCD digits per result; must satisfy 10^DIGITS > 2^WIDTH − 1.
- Clock  input  1  sole clock, rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Start  input  1  active-high request; sampled only in IDLE.
- Quotient  input  WIDTH  unsigned quotient from divider.
- Remainder  input  WIDTH  unsigned remainder from divider.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when new BCD results are valid.
- QuotBCD  output  4*DIGITS  packed BCD of Quotient; digit 0 in bits [3:0].
- RemBCD  output  4*DIGITS  packed BCD of Remainder; digit 0 in bits [3:0].

## Operation
- States: IDLE, SHIFT.
- Reset (Resetn=0, asynchronous): state=IDLE, Busy=0, Done=0, QuotBCD=0, RemBCD=0, internal shift registers and bit counter cleared. All outputs stay at these values while Resetn is low.
- IDLE → SHIFT when Start=1 at a rising edge. On that edge:
  - copy Quotient and Remainder into two binary shift registers;
  - clear both BCD accumulators (4*DIGITS bits each);
  - load the bit counter with WIDTH.
- SHIFT, each edge, for the quotient and remainder paths independently:
  - add 3 to every BCD nibble ≥ 5;
  - shift {BCD, binary} left by one, so the binary MSB enters BCD bit 0;
  - decrement the counter.
- When the counter goes from 1 to 0, on that same edge:
  - load QuotBCD and RemBCD with the final corrected and shifted accumulators;
  - set Done=1 and return to IDLE.
- Done is high for exactly one cycle and is cleared on the next edge.
- QuotBCD and RemBCD hold their last values until the next completion. They never show intermediate values.
- Start while in SHIFT is ignored. There is no queueing, and the inputs are not re-sampled mid-conversion.
- Quotient and Remainder may change freely after the Start edge without affecting the conversion in progress.
- Nibble add-3 uses 4-bit arithmetic. No nibble exceeds 9 after the final shift when the DIGITS constraint holds.
- Out-of-range parameters (DIGITS too small) are unsupported. Upper digits are silently truncated.

## Timing
- Start sampled at edge E0.
- Busy=1 from E0 through edge E0+WIDTH, i.e. for WIDTH cycles.
- Results and Done=1 appear after edge E0+WIDTH. Latency is WIDTH cycles from the Start edge.
- Back-to-back operation: a Start that is high in the Done cycle (state already IDLE) is accepted. Sustained throughput is one conversion per WIDTH+1 cycles.
- Start held high continuously restarts a conversion on every IDLE cycle, i.e. the cycle carrying each Done.
- Reset asserted mid-conversion aborts it immediately. No Done is produced, and all outputs read 0 once reset is released.
- First Start accepted is the one sampled at the first rising edge after Resetn deasserts.

## Test plan
- WIDTH=4, DIGITS=2: Quotient=15, Remainder=0, pulse Start → after 4 cycles Done=1 for one cycle, QuotBCD=8'h15, RemBCD=8'h00, Busy high for exactly 4 cycles.
- Divider output for 13/4 (Quotient=3, Remainder=1) → QuotBCD=8'h03, RemBCD=8'h01. Then 0/0 inputs (Quotient=0, Remainder=0) → both 8'h00, with Done pulsing each time.
- WIDTH=8, DIGITS=3: Quotient=255, Remainder=199 → QuotBCD=12'h255, RemBCD=12'h199 after 8 cycles.
- Start re-pulsed twice during SHIFT, with the inputs changed to 9/9 mid-conversion → the first result (from inputs at the Start edge) is unaffected. Exactly one Done, no second conversion.
- Resetn driven low at cycle 2 of a conversion of Quotient=15 → outputs 0 immediately, no Done. After release, Start with Quotient=7, Remainder=2 → QuotBCD=8'h07, RemBCD=8'h02.
- Start held high constantly with fixed inputs Quotient=12, Remainder=3 → Done pulses every 5 cycles, QuotBCD=8'h12, RemBCD=8'h03 stable.

Source files
------------

// File: rtl/div_result_bcd.sv
// div_result_bcd
//   Sequential binary-to-BCD converter for the integer divider's results.
//   On a Start pulse in IDLE it captures Quotient and Remainder and runs
//   shift-and-add-3 (double-dabble) on both in parallel, one bit per clock.
//   After WIDTH shift cycles the packed BCD results are loaded and Done
//   pulses for one cycle.
//
// Ports
//   Clock      in   sole clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   Start      in   conversion request, sampled only in IDLE
//   Quotient   in   [WIDTH-1:0]    unsigned quotient
//   Remainder  in   [WIDTH-1:0]    unsigned remainder
//   Busy       out  high while a conversion is running
//   Done       out  one-cycle pulse when QuotBCD/RemBCD are updated
//   QuotBCD    out  [4*DIGITS-1:0] packed BCD of Quotient, digit 0 in [3:0]
//   RemBCD     out  [4*DIGITS-1:0] packed BCD of Remainder, digit 0 in [3:0]

module div_result_bcd #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Quotient,
    input  logic [WIDTH-1:0]      Remainder,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   QuotBCD,
    output logic [4*DIGITS-1:0]   RemBCD
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [WIDTH-1:0] q_bin, r_bin;
    logic [BW-1:0]    q_acc, r_acc;
    logic [CW-1:0]    cnt;

    // Add 3 to every nibble >= 5 so the following left shift carries into
    // the next decimal digit. 4-bit wrap is harmless: corrected nibbles
    // never exceed 12.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] bcd);
        logic [BW-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

    // One double-dabble step per path: {corrected BCD, binary} << 1, so the
    // binary MSB lands in BCD bit 0. The top BCD bit falls off the end.
    logic [BW+WIDTH-1:0] q_step, r_step;
    logic [BW-1:0]       q_acc_nxt, r_acc_nxt;
    logic [WIDTH-1:0]    q_bin_nxt, r_bin_nxt;

    always_comb begin
        q_step    = {add3(q_acc), q_bin} << 1;
        r_step    = {add3(r_acc), r_bin} << 1;
        q_acc_nxt = q_step[BW+WIDTH-1:WIDTH];
        r_acc_nxt = r_step[BW+WIDTH-1:WIDTH];
        q_bin_nxt = q_step[WIDTH-1:0];
        r_bin_nxt = r_step[WIDTH-1:0];
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            q_bin   <= '0;
            r_bin   <= '0;
            q_acc   <= '0;
            r_acc   <= '0;
            cnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            QuotBCD <= '0;
            RemBCD  <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        q_bin <= Quotient;
                        r_bin <= Remainder;
                        q_acc <= '0;
                        r_acc <= '0;
                        cnt   <= CW'(WIDTH);
                        Busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    q_acc <= q_acc_nxt;
                    r_acc <= r_acc_nxt;
                    q_bin <= q_bin_nxt;
                    r_bin <= r_bin_nxt;
                    cnt   <= cnt - CW'(1);
                    // Last bit: publish results straight from the step logic
                    // so the outputs never show a partial accumulator.
                    if (cnt == CW'(1)) begin
                        QuotBCD <= q_acc_nxt;
                        RemBCD  <= r_acc_nxt;
                        Done    <= 1'b1;
                        Busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
module tb_div_result_bcd;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Start4, Start8;
    logic [3:0] q4, r4;
    logic [7:0] q8, r8;
    logic       Busy4, Done4, Busy8, Done8;
    logic [7:0]  QuotBCD4, RemBCD4;
    logic [11:0] QuotBCD8, RemBCD8;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clock = ~Clock;

    div_result_bcd #(.WIDTH(4), .DIGITS(2)) dut4 (
        .Clock(Clock), .Resetn(Resetn), .Start(Start4),
        .Quotient(q4), .Remainder(r4),
        .Busy(Busy4), .Done(Done4), .QuotBCD(QuotBCD4), .RemBCD(RemBCD4)
    );

    div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut8 (
        .Clock(Clock), .Resetn(Resetn), .Start(Start8),
        .Quotient(q8), .Remainder(r8),
        .Busy(Busy8), .Done(Done8), .QuotBCD(QuotBCD8), .RemBCD(RemBCD8)
    );

    // Reference: decimal digits by plain division.
    function automatic logic [31:0] bcd_of(input int v, input int nd);
        logic [31:0] res;
        int p;
        res = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            res[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic conv4(input int q, input int r, input string tag);
        int  busy_n;
        bit  got;
        @(negedge Clock);
        Start4 = 1'b1; q4 = q[3:0]; r4 = r[3:0];
        @(negedge Clock);
        Start4 = 1'b0; q4 = 4'($urandom); r4 = 4'($urandom);
        busy_n = 0; got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (Done4) got = 1;
            else begin
                if (Busy4) busy_n++;
                @(negedge Clock);
            end
        end
        check({tag, " done"}, 32'(got), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd4);
        check({tag, " busy_at_done"}, 32'(Busy4), 32'd0);
        check({tag, " quot"}, 32'(QuotBCD4), bcd_of(q, 2));
        check({tag, " rem"}, 32'(RemBCD4), bcd_of(r, 2));
        @(negedge Clock);
        check({tag, " done_pulse"}, 32'(Done4), 32'd0);
    endtask

    task automatic conv8(input int q, input int r, input string tag);
        int  busy_n;
        bit  got;
        @(negedge Clock);
        Start8 = 1'b1; q8 = q[7:0]; r8 = r[7:0];
        @(negedge Clock);
        Start8 = 1'b0; q8 = 8'($urandom); r8 = 8'($urandom);
        busy_n = 0; got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            if (Done8) got = 1;
            else begin
                if (Busy8) busy_n++;
                @(negedge Clock);
            end
        end
        check({tag, " done"}, 32'(got), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, " quot"}, 32'(QuotBCD8), bcd_of(q, 3));
        check({tag, " rem"}, 32'(RemBCD8), bcd_of(r, 3));
        @(negedge Clock);
        check({tag, " done_pulse"}, 32'(Done8), 32'd0);
    endtask

    initial begin
        int n_done;
        int no_busy;
        Resetn = 1'b0;
        Start4 = 1'b0; Start8 = 1'b0;
        q4 = '0; r4 = '0; q8 = '0; r8 = '0;

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst busy4", 32'(Busy4), 32'd0);
        check("rst done4", 32'(Done4), 32'd0);
        check("rst quot4", 32'(QuotBCD4), 32'd0);
        check("rst rem4", 32'(RemBCD4), 32'd0);
        check("rst busy8", 32'(Busy8), 32'd0);
        check("rst quot8", 32'(QuotBCD8), 32'd0);
        Resetn = 1'b1;

        // Directed cases
        conv4(15, 0, "q15r0");
        conv4(3, 1, "q3r1");
        conv4(0, 0, "q0r0");
        conv8(255, 199, "w8_255_199");
        conv8(0, 99, "w8_0_99");

        // Random cases against the decimal model
        for (int i = 0; i < 10; i++)
            conv4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), $sformatf("rnd4_%0d", i));
        for (int i = 0; i < 8; i++)
            conv8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), $sformatf("rnd8_%0d", i));

        // Start re-pulsed during SHIFT with changed inputs: ignored
        @(negedge Clock);
        Start4 = 1'b1; q4 = 4'd5; r4 = 4'd4;
        @(negedge Clock); Start4 = 1'b0; q4 = 4'd9; r4 = 4'd9;
        @(negedge Clock); Start4 = 1'b1;
        @(negedge Clock); Start4 = 1'b0;
        @(negedge Clock); Start4 = 1'b1;
        @(negedge Clock); Start4 = 1'b0;
        check("midstart done", 32'(Done4), 32'd1);
        check("midstart quot", 32'(QuotBCD4), bcd_of(5, 2));
        check("midstart rem", 32'(RemBCD4), bcd_of(4, 2));
        n_done = 0; no_busy = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (Done4) n_done++;
            if (Busy4) no_busy = 0;
        end
        check("midstart extra_done", 32'(n_done), 32'd0);
        check("midstart no_restart", 32'(no_busy), 32'd1);

        // Reset mid-conversion aborts it
        @(negedge Clock);
        Start4 = 1'b1; q4 = 4'd15; r4 = 4'd3;
        @(negedge Clock); Start4 = 1'b0;
        @(negedge Clock);
        Resetn = 1'b0;
        #1;
        check("abort busy", 32'(Busy4), 32'd0);
        check("abort done", 32'(Done4), 32'd0);
        check("abort quot", 32'(QuotBCD4), 32'd0);
        check("abort rem", 32'(RemBCD4), 32'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (Done4) n_done++;
        end
        check("abort no_done", 32'(n_done), 32'd0);
        check("abort quot_after", 32'(QuotBCD4), 32'd0);
        conv4(7, 2, "after_abort");

        // Start held high: one conversion every 5 cycles
        @(negedge Clock);
        Start4 = 1'b1; q4 = 4'd12; r4 = 4'd3;
        n_done = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clock);
            if (Done4) begin
                n_done++;
                check($sformatf("held spacing@%0d", i), 32'(i % 5), 32'd0);
                check($sformatf("held quot@%0d", i), 32'(QuotBCD4), bcd_of(12, 2));
                check($sformatf("held rem@%0d", i), 32'(RemBCD4), bcd_of(3, 2));
            end
        end
        Start4 = 1'b0;
        check("held done_count", 32'(n_done), 32'd4);
        repeat (6) @(negedge Clock);
        check("held idle", 32'(Busy4), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
